// File: rtl/imem_loader.sv
// Boot loader that unpacks a length/data/checksum byte frame into 32-bit imem writes.
// The core is held in reset until a complete frame with a matching checksum has been written.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // The length field is always 16 bits wide, so compare in 17 bits.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state_q;
    logic [7:0]            len_lo_q;
    logic [16:0]           n_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           word_q;
    logic [7:0]            chk_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  cpu_hold_q;
    logic                  done_q;
    logic                  err_q;
    logic [ADDR_WIDTH:0]   words_loaded_q;

    logic                  accept;
    logic [16:0]           n_d;
    logic [31:0]           word_d;
    logic [7:0]            chk_d;
    logic [ADDR_WIDTH:0]   words_loaded_d;
    logic                  last_word;

    assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
    assign accept   = in_valid && in_ready;

    assign n_d            = {1'b0, in_data, len_lo_q};
    assign chk_d          = chk_q ^ in_data;
    assign words_loaded_d = words_loaded_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_word      = (17'(words_loaded_d) == n_q);

    // Incoming byte lands in the lane selected by byte_cnt (little-endian word).
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_d[8*gi +: 8] = (byte_cnt_q == 2'(gi)) ? in_data : word_q[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_LEN0;
            len_lo_q       <= 8'h00;
            n_q            <= 17'h0;
            byte_cnt_q     <= 2'd0;
            word_q         <= 32'h0;
            chk_q          <= 8'h00;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= 32'h0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            case (state_q)
                S_LEN0: begin
                    if (accept) begin
                        len_lo_q <= in_data;
                        state_q  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        n_q <= n_d;
                        if (n_d == 17'h0) begin
                            state_q <= S_CHK;
                        end else if (n_d > MAX_WORDS) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q     <= word_d;
                        chk_q      <= chk_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            imem_wdata_q <= word_d;
                            imem_addr_q  <= words_loaded_q[ADDR_WIDTH-1:0];
                            imem_we_q    <= 1'b1;
                            state_q      <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    imem_we_q      <= 1'b0;
                    words_loaded_q <= words_loaded_d;
                    state_q        <= last_word ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    if (accept) begin
                        if (in_data == chk_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                end
                default: begin
                    state_q <= S_LEN0;
                end
            endcase
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames for imem_loader, checked against a frame-level
// reference model that derives the expected writes and final status from the byte list.
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Write monitor: logs every strobe cycle and counts protocol violations.
    int          wr_cnt = 0;
    int          dbl_cnt = 0;
    int          rdy_bad = 0;
    logic        prev_we = 1'b0;
    logic [AW-1:0] wr_addr_log [0:2047];
    logic [31:0]   wr_data_log [0:2047];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 2048) begin
                wr_addr_log[wr_cnt] <= imem_addr;
                wr_data_log[wr_cnt] <= imem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (imem_we === 1'b1 && prev_we === 1'b1) dbl_cnt <= dbl_cnt + 1;
        if (in_ready !== !(imem_we || done || err)) rdy_bad <= rdy_bad + 1;
        prev_we <= imem_we;
    end

    logic [7:0] fr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int waitc;
        in_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waitc    = 0;
        while (in_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) check("ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Reference model: parse the frame in fr, then drive it and compare.
    task automatic run_frame(input string tag, input int max_gap);
        int            n;
        bit            len_err;
        int            nbytes;
        logic [7:0]    x;
        logic [31:0]   exp_words[$];
        bit            exp_done;
        int            base, dbl0, rdy0;
        n       = int'(fr[0]) + 256 * int'(fr[1]);
        len_err = (n > (1 << AW));
        x       = 8'h00;
        exp_words.delete();
        if (!len_err) begin
            for (int w = 0; w < n; w++) begin
                exp_words.push_back({fr[2+4*w+3], fr[2+4*w+2], fr[2+4*w+1], fr[2+4*w]});
                for (int k = 0; k < 4; k++) x = x ^ fr[2+4*w+k];
            end
        end
        nbytes   = len_err ? 2 : (3 + 4 * n);
        exp_done = !len_err && (fr[nbytes-1] == x);
        base = wr_cnt;
        dbl0 = dbl_cnt;
        rdy0 = rdy_bad;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(fr[i], max_gap);
            if (i >= 2 && i < nbytes - 1 && ((i - 2) % 4) == 3) begin
                check({tag, "_we_latency"}, 64'(imem_we), 64'd1);
                check({tag, "_we_addr"}, 64'(imem_addr), 64'(((i - 2) / 4) % (1 << AW)));
                check({tag, "_we_data"}, 64'(imem_wdata), 64'(exp_words[(i - 2) / 4]));
            end
        end
        check({tag, "_done_next"}, 64'(done), 64'(exp_done));
        check({tag, "_err_next"}, 64'(err), 64'(!exp_done));
        check({tag, "_hold_next"}, 64'(cpu_hold), 64'(!exp_done));
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_nwrites"}, 64'(wr_cnt - base), 64'(exp_words.size()));
        for (int w = 0; w < exp_words.size() && (base + w) < 2048; w++) begin
            check({tag, "_log_addr"}, 64'(wr_addr_log[base+w]), 64'(w % (1 << AW)));
            check({tag, "_log_data"}, 64'(wr_data_log[base+w]), 64'(exp_words[w]));
        end
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_words.size()));
        check({tag, "_done_final"}, 64'(done), 64'(exp_done));
        check({tag, "_err_final"}, 64'(err), 64'(!exp_done));
        check({tag, "_strobe_width"}, 64'(dbl_cnt - dbl0), 64'd0);
        check({tag, "_ready_decode"}, 64'(rdy_bad - rdy0), 64'd0);
    endtask

    task automatic load_frame2(input logic [7:0] chk);
        fr = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h0A, 8'h00, 8'h09, 8'h20, chk};
    endtask

    initial begin
        int          n;
        logic [7:0]  x;
        logic [7:0]  b;

        #2 reset = 1'b0;
        #1 check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        fr = '{8'h00, 8'h00, 8'h00};
        run_frame("n0", 0);

        do_reset();
        load_frame2(8'h0E);
        run_frame("f2", 0);

        do_reset();
        load_frame2(8'h0E);
        run_frame("f2_gaps", 5);

        do_reset();
        load_frame2(8'h0F);
        run_frame("f2_badchk", 2);

        do_reset();
        fr = '{8'h01, 8'h01};
        run_frame("n257", 1);

        do_reset();
        fr = '{8'($urandom), 8'($urandom_range(255, 2))};
        run_frame("n_big", 0);

        do_reset();
        fr = '{8'h00, 8'h01};
        x  = 8'h00;
        for (int i = 0; i < 4 * 256; i++) begin
            b = 8'($urandom);
            fr.push_back(b);
            x = x ^ b;
        end
        fr.push_back(x);
        run_frame("n256", 0);

        // Abort in the middle of the first write strobe, then reload.
        do_reset();
        load_frame2(8'h0E);
        for (int i = 0; i < 6; i++) send_byte(fr[i], 0);
        check("abort_we_before", 64'(imem_we), 64'd1);
        #1 reset = 1'b0;
        #1 check_reset_values("abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame("reload", 1);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            n  = $urandom_range(9, 1);
            fr = '{8'(n), 8'h00};
            x  = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                fr.push_back(b);
                x = x ^ b;
            end
            fr.push_back(($urandom_range(3, 0) == 0) ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
            run_frame("rand", 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
